// File: rtl/dmem_mmio_if.sv
// CPU data-memory bus: byte address, store data and strobe out of the CPU,
// same-cycle load data back from the data-memory stage.
interface dmem_mmio_if #(
  parameter int n = 32
);
  logic [n-1:0] aluout;
  logic [n-1:0] writedata;
  logic         memwrite;
  logic [n-1:0] readdata;

  modport master (
    output aluout,
    output writedata,
    output memwrite,
    input  readdata
  );

  modport slave (
    input  aluout,
    input  writedata,
    input  memwrite,
    output readdata
  );
endinterface

// File: rtl/dmem_mmio.sv
// Data-memory stage: word RAM plus MMIO window (LED, and the compare timer when
// DMEM_TIMER_EN is defined). Loads are combinational, stores commit at the edge.
module dmem_mmio #(
  parameter int n     = 32,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          reset,
  dmem_mmio_if.slave    bus,
  output logic [n-1:0]  led,
  output logic          irq
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OFF_LED     = 3'd0,
    OFF_COUNT   = 3'd1,
    OFF_COMPARE = 3'd2,
    OFF_STATUS  = 3'd3,
    OFF_CTRL    = 3'd4
  } mmio_off_e;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_AUTOCLR = 1;
  localparam int CTRL_IRQEN   = 2;

  logic          is_mmio;
  logic [AW-1:0] ram_idx;
  logic [2:0]    off;
  logic          ram_we;
  logic          mmio_we;
  logic          wr_led;
  logic [n-1:0]  rd_mmio;
  logic          unused_addr_bits;

  assign is_mmio = bus.aluout[n-1];
  assign ram_idx = bus.aluout[AW+1:2];
  assign off     = bus.aluout[4:2];
  assign ram_we  = bus.memwrite & ~is_mmio;
  assign mmio_we = bus.memwrite &  is_mmio;
  assign wr_led  = mmio_we && (off == OFF_LED);

  // Byte-lane bits and the RAM alias bits are deliberately ignored.
  assign unused_addr_bits = &{1'b0, bus.aluout[1:0], bus.aluout[n-2:AW+2]};

  // ---------------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------------
  logic [n-1:0] mem [DEPTH];

  // NOTE: the RAM array has no reset so it maps onto plain memory and keeps its
  // contents across a reset; only the control registers below are cleared.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_idx] <= bus.writedata;
  end

  // ---------------------------------------------------------------------------
  // LED register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values, regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       led <= '0;
    else if (wr_led) led <= bus.writedata;
  end

`ifdef DMEM_TIMER_EN
  // ---------------------------------------------------------------------------
  // Compare timer with sticky flag
  // ---------------------------------------------------------------------------
  logic [n-1:0] count;
  logic [n-1:0] compare;
  logic         flag;
  logic [2:0]   ctrl;
  logic         match;
  logic         wr_count;
  logic         wr_compare;
  logic         w1c_status;
  logic         wr_ctrl;

  assign match      = ctrl[CTRL_EN] && (count == compare);
  assign wr_count   = mmio_we && (off == OFF_COUNT);
  assign wr_compare = mmio_we && (off == OFF_COMPARE);
  assign w1c_status = mmio_we && (off == OFF_STATUS) && bus.writedata[0];
  assign wr_ctrl    = mmio_we && (off == OFF_CTRL);

  // The edge always evaluates with the pre-edge CTRL, so a CTRL write only
  // changes timer behaviour from the following edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      compare <= '0;
      flag    <= 1'b0;
      ctrl    <= '0;
    end else begin
      if (wr_count)
        count <= bus.writedata;
      else if (ctrl[CTRL_EN])
        count <= (match && ctrl[CTRL_AUTOCLR]) ? '0 : count + 1'b1;

      if (match)           flag <= 1'b1;
      else if (w1c_status) flag <= 1'b0;

      if (wr_compare) compare <= bus.writedata;
      if (wr_ctrl)    ctrl    <= bus.writedata[2:0];
    end
  end

  assign irq = flag & ctrl[CTRL_IRQEN];
`else
  assign irq = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Load path
  // ---------------------------------------------------------------------------
  // NOTE: default assignment first keeps this combinational block latch-free
  // for offsets with no register behind them.
  always_comb begin
    rd_mmio = '0;
    case (off)
      OFF_LED:     rd_mmio = led;
`ifdef DMEM_TIMER_EN
      OFF_COUNT:   rd_mmio = count;
      OFF_COMPARE: rd_mmio = compare;
      OFF_STATUS:  rd_mmio = {{(n-1){1'b0}}, flag};
      OFF_CTRL:    rd_mmio = {{(n-3){1'b0}}, ctrl};
`endif
      default:     rd_mmio = '0;
    endcase
  end

  always_comb begin
    bus.readdata = is_mmio ? rd_mmio : mem[ram_idx];
  end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-memory stage that consumes the CPU's memory bus (`aluout` as address, `writedata`, `memwrite`) and returns `readdata` in the same cycle, as the single-cycle datapath requires. It holds a word-addressed RAM plus a small memory-mapped I/O window: an LED register and an optional compare timer with a sticky interrupt flag. It sits directly downstream of `cpu`.

## Interface

- `n`, 32, data/address width
- `DEPTH`, 64, RAM depth in words (power of two, ≥ 4)
- `clk`  in  1  system clock, rising-edge active
- `reset`  in  1  asynchronous, active-high reset
- `aluout`  in  n  byte address from CPU
- `writedata`  in  n  store data
- `memwrite`  in  1  store strobe, commits at the rising edge
- `readdata`  out  n  load data, combinational from `aluout` and state
- `led`  out  n  LED register contents
- `irq`  out  1  timer interrupt request (`flag & CTRL[2]`)

## Operation

- Region select is `aluout[31]`. 0 selects RAM; 1 selects MMIO.
- `aluout[1:0]` is ignored; there are no byte lanes.
- RAM:
  - Index is `aluout[log2(DEPTH)+1:2]`. Upper bits are ignored, so addresses alias modulo DEPTH words.
  - Writes occur on `memwrite`. RAM is not reset, and reads of never-written words are X.
- MMIO offsets (`aluout[4:2]`):
  - 0 LED: RW.
  - 1 COUNT: read returns the counter; a write loads the counter.
  - 2 COMPARE: RW.
  - 3 STATUS: bit0 = flag. Write 1 to clear; writing 0 has no effect; other bits read 0.
  - 4 CTRL: bit0 enable, bit1 auto-clear count on match, bit2 irq enable. Other bits read 0 and are not stored.
  - 5–7: read 0, writes ignored.
- Timer, evaluated at each rising edge with CTRL.enable = 1:
  - If `count == compare`: set flag. Count goes to 0 if auto-clear, else `count+1`.
  - Otherwise: `count <= count+1`, wrapping from 2^n−1 to 0.
  - With enable = 0, count and flag hold.
- Simultaneous events:
  - A CPU write to COUNT overrides the increment and auto-clear in the same edge. Flag set by a match in that edge still occurs.
  - A W1C to STATUS in the same edge as a match leaves the flag set.
  - A CTRL write takes effect from the next edge; the current edge uses the old CTRL.
- Reset (asynchronous, any time, including mid-count):
  - `led`, count, compare, flag and CTRL go to 0 immediately.
  - `irq` is 0.
  - `readdata` reflects the cleared registers for MMIO addresses.
  - RAM contents are retained.

## Timing

- Load latency is 0 cycles: `readdata` is valid combinationally in the same cycle `aluout` is presented.
- Store latency is 1 edge. A read of the same address in the same cycle returns the old value; the next cycle returns the new value.
- `irq` is combinational from registered flag and CTRL. It rises in the cycle after the matching edge and falls in the cycle after a W1C edge or CTRL.bit2 clear.
- With `count` at C on an edge, enable set, no match and no write, COUNT reads C+1 in the following cycle.

## Configuration

- `DMEM_TIMER_EN` defined:
  - Timer, COMPARE, STATUS and CTRL are implemented as above.
- Not defined:
  - Offsets 1–4 read 0 and writes to them are ignored.
  - No counter flops exist.
  - `irq` is tied to 0.
  - RAM and LED behaviour are unchanged.

## Test plan

- Reset, then store `32'hdeadbeef` to address `0x00000010`, then load it. Required: same-cycle `readdata` is old/X, the next cycle reads `deadbeef`, and address `0x00000110` (DEPTH = 64) reads the same word.
- Store `32'h000000a5` to `0x80000000`. Required: `led` = `000000a5` after the edge; reading offset 0 returns it; reading offset 6 returns 0.
- Set COMPARE = 3 and CTRL = `3'b101`. Required: COUNT reads 0,1,2,3 on successive cycles. On the edge where count == 3 the flag sets, COUNT reads 4 in the next cycle, and `irq` = 1 from that cycle.
- Repeat with CTRL = `3'b111`. Required: COUNT goes 3 → 0 at the match. Then W1C STATUS = 1 on a non-match edge: flag and `irq` drop next cycle.
- Set COMPARE = 5, write COUNT = 5 with enable set. Required: the loaded value (5) wins over the increment. The following edge matches and sets the flag.
- Assert `reset` mid-count (count = 7, flag = 1, `led` = `ff`). Required: `led`, COUNT, flag and `irq` are 0 immediately, before any clock edge. A previously stored RAM word still reads back.
